mouse_stim_prog: RTL and testbench
==================================

Name: mouse_stim_prog

Overview:
- Parametrised simulation-side mouse stimulus generator.
- Drives `mouse_left`, `mouse_xpos` and `mouse_ypos` into drawing/control blocks under test. It scripts a full gesture: idle at a start position, press, drag in fixed steps, release.
- Supports an optional repeat mode, a pause input, and status outputs for bench synchronisation.
- Replaces single fixed-delay press generators in `sim/` benches.

Parameters:
- POS_W, 12, width of position outputs.
- CTR_W, 32, width of the internal delay counter.
- WAIT_CYCLES, 500_000, enabled cycles in WAIT before press (>=1).
- STEP_PERIOD, 1000, enabled cycles per drag step (>=1).
- N_STEPS, 16, drag steps while pressed (0 = hold one STEP_PERIOD, no movement).
- RELEASE_CYCLES, 1000, enabled cycles in RELEASE after button release (>=1).
- X_START, 0, start x position.
- Y_START, 0, start y position.
- X_STEP, 1, signed x increment per step.
- Y_STEP, 1, signed y increment per step.
- X_MAX, 1023, x clamp upper bound.
- Y_MAX, 767, y clamp upper bound.
- LOOP, 0, 1 = restart gesture after RELEASE; 0 = stop in DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  advance enable; low freezes all state, counters and outputs
- mouse_left  out  1  left button level
- mouse_xpos  out  POS_W  x position
- mouse_ypos  out  POS_W  y position
- done  out  1  sticky; gesture finished (LOOP=0 only)
- loop_count  out  8  completed gestures, wraps 255->0

Behaviour:
- All outputs are registered. One clock, `clk`; reset is synchronous and active-high on `rst`. `rst` dominates `en`.
- Reset values: `mouse_left`=0, `mouse_xpos`=0, `mouse_ypos`=0, `done`=0, `loop_count`=0. State=WAIT, counter=0, step_cnt=0.
- Edge numbering: edge 1 = first rising edge with `rst`=0 and `en`=1. Non-enabled edges are not counted.
- WAIT:
  - At every enabled edge, `mouse_xpos`<=X_START and `mouse_ypos`<=Y_START, so they are valid after edge 1. `mouse_left`<=0.
  - If counter==WAIT_CYCLES-1: state<=DRAG, counter<=0, `mouse_left`<=1. Otherwise counter++.
  - Result: `mouse_left` is high after edge WAIT_CYCLES.
- DRAG:
  - If counter==STEP_PERIOD-1: counter<=0. If N_STEPS>0, apply a step to both axes. Otherwise counter++.
  - Last step: when N_STEPS==0, or step_cnt==N_STEPS-1 at a step edge, then state<=RELEASE, `mouse_left`<=0 and step_cnt<=0 on that same edge. Otherwise step_cnt++.
  - On the final step edge, position and `mouse_left` update together.
- Step arithmetic:
  - Computed signed at POS_W+2 bits: next = cur + STEP.
  - Clamped to [0, X_MAX] or [0, Y_MAX] per axis. No wrap-around.
  - Each axis clamps independently.
- RELEASE:
  - `mouse_left`=0; position holds.
  - If counter==RELEASE_CYCLES-1: counter<=0 and `loop_count`++.
  - On that edge, LOOP=1 returns state to WAIT; the position reloads on the next enabled WAIT edge. LOOP=0 goes to DONE with `done`<=1.
- DONE:
  - Terminal until `rst`. Outputs hold and the counter stops.
- `en`=0 in any state: no change to any register.
- `rst` mid-gesture: all registers return to reset values on that edge, and the gesture restarts from WAIT.
- Counter compares are exact equality on CTR_W bits. Parameters exceeding 2^CTR_W are illegal and checked by an elaboration assertion.

Test Plan:
- Shared settings: WAIT_CYCLES=4, STEP_PERIOD=2, N_STEPS=3, RELEASE_CYCLES=3, X_START=100, Y_START=50, X_STEP=10, Y_STEP=-5, LOOP=0, `en`=1.
  - Expected: after edge 1 pos=(100,50), left=0. After edge 4 left=1. After edge 6 (110,45). After edge 8 (120,40). After edge 10 (130,35) with left=0. After edge 13 done=1, loop_count=1. Stable thereafter.
- Clamp: X_START=635, X_STEP=10, X_MAX=639, Y_START=3, Y_STEP=-5, N_STEPS=2 -> first step (639,0), second step (639,0); no wrap.
- Pause: first case with `en`=0 for 5 cycles after edge 6 -> all outputs frozen during the pause; every later event is shifted by exactly 5 clocks.
- LOOP=1, first case -> after edge 13 loop_count=1, done stays 0. After edge 14 pos=(100,50). Left rises again after edge 17.
- N_STEPS=0 -> left high after edge 4, low after edge 6, position stays (100,50).
- Reset at edge 7 (mid-DRAG) -> next cycle: all outputs 0, done=0, loop_count=0. The gesture then replays the first-case timing from a new edge 1.

Source files
------------

// File: rtl/mouse_stim_prog.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_stim_prog
//  Purpose  : Scripted mouse gesture generator for simulation benches.
//             Idles at a start position, presses the left button, drags in
//             fixed signed steps (clamped per axis), releases, then either
//             stops (done) or restarts the gesture (LOOP=1).
//  Ports    : clk        - system clock
//             rst        - synchronous reset, active-high (dominates en)
//             en         - advance enable; low freezes every register
//             mouse_left - left button level
//             mouse_xpos - x position (POS_W bits)
//             mouse_ypos - y position (POS_W bits)
//             done       - sticky, gesture finished (LOOP=0 only)
//             loop_count - completed gestures, wraps 255->0
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_stim_prog #(
    parameter int POS_W          = 12,
    parameter int CTR_W          = 32,
    parameter int WAIT_CYCLES    = 500_000,
    parameter int STEP_PERIOD    = 1000,
    parameter int N_STEPS        = 16,
    parameter int RELEASE_CYCLES = 1000,
    parameter int X_START        = 0,
    parameter int Y_START        = 0,
    parameter int X_STEP         = 1,
    parameter int Y_STEP         = 1,
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int LOOP           = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             mouse_left,
    output logic [POS_W-1:0] mouse_xpos,
    output logic [POS_W-1:0] mouse_ypos,
    output logic             done,
    output logic [7:0]       loop_count
);

    localparam logic [1:0] c_st_wait    = 2'd0;
    localparam logic [1:0] c_st_drag    = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [CTR_W-1:0] c_ctr_one     = CTR_W'(1);
    localparam logic [CTR_W-1:0] c_wait_last   = CTR_W'(WAIT_CYCLES - 1);
    localparam logic [CTR_W-1:0] c_step_last   = CTR_W'(STEP_PERIOD - 1);
    localparam logic [CTR_W-1:0] c_rel_last    = CTR_W'(RELEASE_CYCLES - 1);
    localparam logic [CTR_W-1:0] c_nsteps_last = CTR_W'((N_STEPS > 0) ? (N_STEPS - 1) : 0);

    localparam logic [POS_W-1:0]        c_x_start = POS_W'(X_START);
    localparam logic [POS_W-1:0]        c_y_start = POS_W'(Y_START);
    localparam logic signed [POS_W+1:0] c_x_step  = (POS_W+2)'(X_STEP);
    localparam logic signed [POS_W+1:0] c_y_step  = (POS_W+2)'(Y_STEP);
    localparam logic signed [POS_W+1:0] c_x_max   = (POS_W+2)'(X_MAX);
    localparam logic signed [POS_W+1:0] c_y_max   = (POS_W+2)'(Y_MAX);

    // Largest count a CTR_W-bit counter can represent (plus one).
    localparam longint c_ctr_span = longint'(1) << CTR_W;

    generate
        if ((WAIT_CYCLES < 1) || (longint'(WAIT_CYCLES) > c_ctr_span) ||
            (STEP_PERIOD < 1) || (longint'(STEP_PERIOD) > c_ctr_span) ||
            (RELEASE_CYCLES < 1) || (longint'(RELEASE_CYCLES) > c_ctr_span) ||
            (N_STEPS < 0) || (longint'(N_STEPS) > c_ctr_span)) begin : g_bad_params
            $error("mouse_stim_prog: cycle/step parameter out of range for CTR_W");
        end
    endgenerate

    // Step one axis: signed add at POS_W+2 bits so neither underflow below
    // zero nor overflow past the limit can wrap, then clamp to [0, lim].
    function automatic logic [POS_W-1:0] f_step(
        input logic [POS_W-1:0]        cur,
        input logic signed [POS_W+1:0] step,
        input logic signed [POS_W+1:0] lim
    );
        logic signed [POS_W+1:0] sum;
        sum = $signed({2'b00, cur}) + step;
        if (sum[POS_W+1]) begin
            return '0;
        end else if (sum > lim) begin
            return lim[POS_W-1:0];
        end else begin
            return sum[POS_W-1:0];
        end
    endfunction

    logic [1:0]       r_state;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] r_step_cnt;
    logic             r_left;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             r_done;
    logic [7:0]       r_loop_count;

    logic [1:0]       w_state_nxt;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic [CTR_W-1:0] w_step_nxt;
    logic             w_left_nxt;
    logic [POS_W-1:0] w_x_nxt;
    logic [POS_W-1:0] w_y_nxt;
    logic             w_done_nxt;
    logic [7:0]       w_lc_nxt;
    logic [POS_W-1:0] w_x_stepped;
    logic [POS_W-1:0] w_y_stepped;

    assign w_x_stepped = f_step(r_x, c_x_step, c_x_max);
    assign w_y_stepped = f_step(r_y, c_y_step, c_y_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_wait;
            r_ctr        <= '0;
            r_step_cnt   <= '0;
            r_left       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_done       <= 1'b0;
            r_loop_count <= 8'd0;
        end else if (en) begin
            r_state      <= w_state_nxt;
            r_ctr        <= w_ctr_nxt;
            r_step_cnt   <= w_step_nxt;
            r_left       <= w_left_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_done       <= w_done_nxt;
            r_loop_count <= w_lc_nxt;
        end
    end

    // Next-state values assume an enabled edge; the register block gates
    // them with en so a paused generator holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_step_nxt  = r_step_cnt;
        w_left_nxt  = r_left;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_done_nxt  = r_done;
        w_lc_nxt    = r_loop_count;
        case (r_state)
            c_st_wait: begin
                // Position is reloaded every WAIT edge so it is valid after
                // the first enabled edge and after every loop restart.
                w_x_nxt    = c_x_start;
                w_y_nxt    = c_y_start;
                w_left_nxt = 1'b0;
                if (r_ctr == c_wait_last) begin
                    w_state_nxt = c_st_drag;
                    w_ctr_nxt   = '0;
                    w_left_nxt  = 1'b1;
                end else begin
                    w_ctr_nxt = r_ctr + c_ctr_one;
                end
            end
            c_st_drag: begin
                if (r_ctr == c_step_last) begin
                    w_ctr_nxt = '0;
                    if (N_STEPS > 0) begin
                        w_x_nxt = w_x_stepped;
                        w_y_nxt = w_y_stepped;
                    end
                    // Final step: move and release on the same edge.
                    if ((N_STEPS == 0) || (r_step_cnt == c_nsteps_last)) begin
                        w_state_nxt = c_st_release;
                        w_left_nxt  = 1'b0;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step_cnt + c_ctr_one;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + c_ctr_one;
                end
            end
            c_st_release: begin
                w_left_nxt = 1'b0;
                if (r_ctr == c_rel_last) begin
                    w_ctr_nxt = '0;
                    w_lc_nxt  = r_loop_count + 8'd1;
                    if (LOOP != 0) begin
                        w_state_nxt = c_st_wait;
                    end else begin
                        w_state_nxt = c_st_done;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + c_ctr_one;
                end
            end
            default: begin
                // Terminal state: everything holds until reset.
            end
        endcase
    end

    assign mouse_left = r_left;
    assign mouse_xpos = r_x;
    assign mouse_ypos = r_y;
    assign done       = r_done;
    assign loop_count = r_loop_count;

endmodule
`default_nettype wire

// File: tb/tb_mouse_stim_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mouse_stim_prog
//  Purpose  : Self-checking bench for mouse_stim_prog. Four instances cover
//             the base gesture, axis clamping, loop mode and zero drag steps.
//             Expected outputs come from a timeline model indexed by the
//             number of enabled edges since reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_stim_prog;

    typedef struct packed {
        logic        left;
        logic [11:0] x;
        logic [11:0] y;
        logic        done;
        logic [7:0]  lc;
    } obs_t;

    logic        clk;
    logic        rst_i  [4];
    logic        en_i   [4];
    logic        left_o [4];
    logic [11:0] x_o    [4];
    logic [11:0] y_o    [4];
    logic        done_o [4];
    logic [7:0]  lc_o   [4];

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: base gesture
    mouse_stim_prog #(
        .WAIT_CYCLES(4), .STEP_PERIOD(2), .N_STEPS(3), .RELEASE_CYCLES(3),
        .X_START(100), .Y_START(50), .X_STEP(10), .Y_STEP(-5), .LOOP(0)
    ) u_base (
        .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .mouse_left(left_o[0]),
        .mouse_xpos(x_o[0]), .mouse_ypos(y_o[0]), .done(done_o[0]), .loop_count(lc_o[0])
    );

    // Instance 1: clamping on both axes
    mouse_stim_prog #(
        .WAIT_CYCLES(4), .STEP_PERIOD(2), .N_STEPS(2), .RELEASE_CYCLES(3),
        .X_START(635), .Y_START(3), .X_STEP(10), .Y_STEP(-5), .X_MAX(639), .LOOP(0)
    ) u_clamp (
        .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .mouse_left(left_o[1]),
        .mouse_xpos(x_o[1]), .mouse_ypos(y_o[1]), .done(done_o[1]), .loop_count(lc_o[1])
    );

    // Instance 2: loop mode
    mouse_stim_prog #(
        .WAIT_CYCLES(4), .STEP_PERIOD(2), .N_STEPS(3), .RELEASE_CYCLES(3),
        .X_START(100), .Y_START(50), .X_STEP(10), .Y_STEP(-5), .LOOP(1)
    ) u_loop (
        .clk(clk), .rst(rst_i[2]), .en(en_i[2]), .mouse_left(left_o[2]),
        .mouse_xpos(x_o[2]), .mouse_ypos(y_o[2]), .done(done_o[2]), .loop_count(lc_o[2])
    );

    // Instance 3: no drag steps
    mouse_stim_prog #(
        .WAIT_CYCLES(4), .STEP_PERIOD(2), .N_STEPS(0), .RELEASE_CYCLES(3),
        .X_START(100), .Y_START(50), .X_STEP(10), .Y_STEP(-5), .LOOP(0)
    ) u_zero (
        .clk(clk), .rst(rst_i[3]), .en(en_i[3]), .mouse_left(left_o[3]),
        .mouse_xpos(x_o[3]), .mouse_ypos(y_o[3]), .done(done_o[3]), .loop_count(lc_o[3])
    );

    // Expected outputs of instance `inst` after `k` enabled edges since reset.
    function automatic obs_t model(int inst, int k);
        obs_t o;
        int w, p, n, r, xs, ys, dx, dy, xm, ym, lp;
        int hold, g, kk, loops, steps, x, y;
        w = 4; p = 2; n = 3; r = 3; xs = 100; ys = 50; dx = 10; dy = -5;
        xm = 1023; ym = 767; lp = 0;
        case (inst)
            1: begin xs = 635; ys = 3; xm = 639; n = 2; end
            2: lp = 1;
            3: n = 0;
            default: ;
        endcase
        o = '0;
        if (k == 0) return o;
        hold  = p * ((n > 0) ? n : 1);
        g     = w + hold + r;
        kk    = (lp != 0) ? (((k - 1) % g) + 1) : ((k < g) ? k : g);
        loops = (lp != 0) ? (k / g) : ((k >= g) ? 1 : 0);
        steps = (kk < w || n == 0) ? 0 : (kk - w) / p;
        if (steps > n) steps = n;
        x = xs; y = ys;
        for (int i = 0; i < steps; i++) begin
            x = x + dx; if (x < 0) x = 0; if (x > xm) x = xm;
            y = y + dy; if (y < 0) y = 0; if (y > ym) y = ym;
        end
        o.left = (kk >= w) && (kk < w + hold);
        o.x    = 12'(x);
        o.y    = 12'(y);
        o.done = (lp == 0) && (k >= g);
        o.lc   = 8'(loops % 256);
        return o;
    endfunction

    function automatic obs_t observe(int inst);
        return {left_o[inst], x_o[inst], y_o[inst], done_o[inst], lc_o[inst]};
    endfunction

    // Drive one clock for one instance; outputs are sampled 1 time unit later.
    task automatic cycle(int inst, logic r, logic e);
        rst_i[inst] = r;
        en_i[inst]  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, a;
        for (int i = 0; i < 4; i++) begin rst_i[i] = 1'b1; en_i[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model(i, 0));
            e = exp_q.pop_front();
            a = observe(i);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL reset inst%0d: got %h want %h", i, a, e);
            end
        end
    endtask

    task automatic test_gesture();
        obs_t e, a;
        cycle(0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back(model(0, k));
            cycle(0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            a = observe(0);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL gesture edge %0d: got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(0, 1'b1, 1'b0);
    endtask

    task automatic test_clamp();
        obs_t e, a;
        cycle(1, 1'b1, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            exp_q.push_back(model(1, k));
            cycle(1, 1'b0, 1'b1);
            e = exp_q.pop_front();
            a = observe(1);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL clamp edge %0d: got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(1, 1'b1, 1'b0);
    endtask

    task automatic test_loop();
        obs_t e, a;
        cycle(2, 1'b1, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(model(2, k));
            cycle(2, 1'b0, 1'b1);
            e = exp_q.pop_front();
            a = observe(2);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL loop edge %0d: got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(2, 1'b1, 1'b0);
    endtask

    task automatic test_no_steps();
        obs_t e, a;
        cycle(3, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            exp_q.push_back(model(3, k));
            cycle(3, 1'b0, 1'b1);
            e = exp_q.pop_front();
            a = observe(3);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL no_steps edge %0d: got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(3, 1'b1, 1'b0);
    endtask

    // Pause for 5 clocks after edge 6: outputs frozen, timeline resumes at 7.
    task automatic test_pause();
        obs_t e, a;
        int   k;
        logic e_en;
        cycle(0, 1'b1, 1'b1);
        k = 0;
        for (int c = 1; c <= 21; c++) begin
            e_en = !(c >= 7 && c <= 11);
            if (e_en) k++;
            exp_q.push_back(model(0, k));
            cycle(0, 1'b0, e_en);
            e = exp_q.pop_front();
            a = observe(0);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL pause clock %0d (edge %0d): got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         c, k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(0, 1'b1, 1'b0);
    endtask

    // Reset asserted on edge 7 (mid-drag), then a full replay from edge 1.
    task automatic test_reset_mid();
        obs_t e, a;
        int   k;
        logic r;
        cycle(0, 1'b1, 1'b1);
        k = 0;
        for (int c = 1; c <= 23; c++) begin
            r = (c == 7);
            k = r ? 0 : k + 1;
            exp_q.push_back(model(0, k));
            cycle(0, r, 1'b1);
            e = exp_q.pop_front();
            a = observe(0);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL reset_mid clock %0d (edge %0d): got left=%0b pos=(%0d,%0d) done=%0b loops=%0d, want left=%0b pos=(%0d,%0d) done=%0b loops=%0d",
                         c, k, a.left, a.x, a.y, a.done, a.lc, e.left, e.x, e.y, e.done, e.lc);
            end
        end
        cycle(0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin rst_i[i] = 1'b1; en_i[i] = 1'b0; end
        test_reset();
        test_gesture();
        test_clamp();
        test_loop();
        test_no_steps();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
